// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 active-low matrix keypad, debounces presses
// and releases on a slow scan tick, and shifts each accepted hex key code into
// a 16-bit entry value that feeds the 4-digit hex display.
//
// Handshake: key_valid is a one-cycle strobe with no ready/back-pressure. It is
// high only in the ACCEPT cycle. key_code, hexs, key_count and pressed take
// their new values on the clock edge that ends that cycle.
module keypad_hex_entry #(
    parameter int SCAN_DIV     = 4096,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] hexs,
    output logic [2:0]  key_count,
    output logic        pressed
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        ACCEPT   = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic [3:0]      col_meta_q,  col_meta_d;
    logic [3:0]      col_s_q,     col_s_d;
    logic [TW-1:0]   tick_cnt_q,  tick_cnt_d;
    logic [1:0]      row_idx_q,   row_idx_d;
    logic [3:0]      pat_q,       pat_d;
    logic [DW-1:0]   db_cnt_q,    db_cnt_d;
    logic [3:0]      key_code_q,  key_code_d;
    logic            key_valid_q, key_valid_d;
    logic [15:0]     hexs_q,      hexs_d;
    logic [2:0]      key_count_q, key_count_d;
    logic            pressed_q,   pressed_d;

    logic            tick;
    logic            col_one_low;
    logic [1:0]      col_idx;
    logic [3:0]      code;
    logic [DW-1:0]   db_next;

    // Scan tick decode, single-key pattern check, column index of the latched pattern.
    always_comb begin
        tick        = (tick_cnt_q == TICK_LAST);
        col_one_low = ($countones(~col_s_q) == 1);
        col_idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!pat_q[i]) begin
                col_idx = 2'(i);
            end
        end
        code    = {row_idx_q, col_idx};
        db_next = db_cnt_q + DW'(1);
    end

    // Next-state logic for the synchronizer, tick divider, scan FSM and entry value.
    always_comb begin
        state_d     = state_q;
        col_meta_d  = col_in;
        col_s_d     = col_meta_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
        row_idx_d   = row_idx_q;
        pat_d       = pat_q;
        db_cnt_d    = db_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        hexs_d      = hexs_q;
        key_count_d = key_count_q;
        pressed_d   = pressed_q;

        unique case (state_q)
            SCAN: begin
                if (tick) begin
                    if (col_one_low) begin
                        // Row is held so the latched column maps onto this row.
                        pat_d    = col_s_q;
                        db_cnt_d = DW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            state_d     = ACCEPT;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        // All-high and multi-key patterns both move to the next row.
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (col_s_q == pat_q) begin
                        db_cnt_d = db_next;
                        if (db_next == DB_DONE) begin
                            state_d     = ACCEPT;
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
            end
            ACCEPT: begin
                key_code_d  = code;
                hexs_d      = {hexs_q[11:0], code};
                key_count_d = (key_count_q == 3'd4) ? 3'd4 : key_count_q + 3'd1;
                pressed_d   = 1'b1;
                db_cnt_d    = '0;
                state_d     = RELEASE;
            end
            RELEASE: begin
                // Any low column (held key or a second key) restarts the release count.
                if (tick) begin
                    if (col_s_q == 4'hF) begin
                        if (db_next == DB_DONE) begin
                            db_cnt_d  = '0;
                            pressed_d = 1'b0;
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = SCAN;
                        end else begin
                            db_cnt_d = db_next;
                        end
                    end else begin
                        db_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        // Clearing the entry takes priority over a key landing in the same cycle.
        if (clr) begin
            hexs_d      = '0;
            key_count_d = '0;
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            col_meta_q  <= 4'hF;
            col_s_q     <= 4'hF;
            tick_cnt_q  <= '0;
            row_idx_q   <= 2'd0;
            pat_q       <= 4'hF;
            db_cnt_q    <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            hexs_q      <= 16'h0000;
            key_count_q <= 3'd0;
            pressed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_meta_q  <= col_meta_d;
            col_s_q     <= col_s_d;
            tick_cnt_q  <= tick_cnt_d;
            row_idx_q   <= row_idx_d;
            pat_q       <= pat_d;
            db_cnt_q    <= db_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            hexs_q      <= hexs_d;
            key_count_q <= key_count_d;
            pressed_q   <= pressed_d;
        end
    end

    // Row drive is a one-cold decode of the registered row index.
    assign row_out   = ~(4'b0001 << row_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign hexs      = hexs_q;
    assign key_count = key_count_q;
    assign pressed   = pressed_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: a keypad model pulls columns low for held keys
// on the active row; accepted codes are kept in a list and the expected entry
// value is rebuilt from the last four codes.
module tb_keypad_hex_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] hexs;
    logic [2:0]  key_count;
    logic        pressed;

    logic [15:0] key_mask;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [3:0]  exp_q[$];

    keypad_hex_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .hexs      (hexs),
        .key_count (key_count),
        .pressed   (pressed)
    );

    // Clock
    always #5 clk = ~clk;

    // Keypad: a held key shorts its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[4*r+c] && (row_out[r] == 1'b0)) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    // Count key_valid pulses.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entry value = last (up to) four accepted codes, newest in the low nibble.
    function automatic logic [31:0] model_hexs();
        int n;
        int lo;
        int v;
        n  = exp_q.size();
        lo = (n > 4) ? n - 4 : 0;
        v  = 0;
        for (int i = lo; i < n; i++) begin
            v = v * 16 + int'(exp_q[i]);
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_count();
        return (exp_q.size() > 4) ? 32'd4 : 32'(exp_q.size());
    endfunction

    // Return at the first negedge after row_out has just become target.
    task automatic wait_row(input logic [3:0] target);
        int n;
        n = 0;
        while (row_out === target && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (row_out !== target && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_row", row_out, target);
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = (key_valid === 1'b1);
        if (!ok) check("valid_timeout", key_valid, 1);
    endtask

    task automatic wait_released();
        int n;
        n = 0;
        while (pressed !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("release_timeout", pressed, 0);
    endtask

    // Press key k, hold it, release it, then compare against the model.
    task automatic press_key(input int k, input bit with_clr, input int hold);
        int p0;
        bit ok;
        p0       = pulses;
        key_mask = 16'd1 << k;
        wait_valid(ok);
        if (ok && with_clr) clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_q.push_back(4'(k));
        if (with_clr) exp_q.delete();
        repeat (hold) @(negedge clk);
        check("pressed_hold", pressed, 1);
        key_mask = 16'h0000;
        wait_released();
        check("key_code", key_code, k);
        check("hexs", hexs, model_hexs());
        check("key_count", key_count, model_count());
        check("pulse_count", pulses - p0, 1);
    endtask

    initial begin
        logic [3:0]  prev;
        logic [15:0] t2_hexs[5];
        int          t2_keys[5];
        int          p0;
        int          n;
        bit          ok;

        t2_keys = '{1, 2, 3, 10, 15};
        t2_hexs = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23AF};

        rst      = 1'b1;
        clr      = 1'b0;
        key_mask = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_row_out", row_out, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_hexs", hexs, 0);
        check("rst_key_count", key_count, 0);
        check("rst_pressed", pressed, 0);
        rst = 1'b0;
        @(negedge clk);

        // Row 2 / column 1 held for well over 20 ticks.
        press_key(9, 1'b0, 100);
        check("t1_row_after_release", row_out, 4'b0111);
        prev = row_out;
        n = 0;
        while (row_out === prev && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("t1_row_resumes", row_out, 4'b1110);

        // Clear, then a five-key sequence.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_q.delete();
        check("clr_hexs", hexs, 0);
        check("clr_key_count", key_count, 0);
        for (int i = 0; i < 5; i++) begin
            press_key(t2_keys[i], 1'b0, 30);
            check("t2_hexs_table", hexs, t2_hexs[i]);
        end
        check("t2_count_sat", key_count, 4);

        // Bounce: key 6 seen for two ticks, gone, then again for two ticks.
        p0 = pulses;
        for (int b = 0; b < 2; b++) begin
            wait_row(4'b1101);
            key_mask = 16'd1 << 6;
            repeat (6) @(negedge clk);
            check("t3_row_held", row_out, 4'b1101);
            repeat (2) @(negedge clk);
            key_mask = 16'h0000;
            repeat (4) @(negedge clk);
            check("t3_row_advanced", row_out, 4'b1011);
        end
        check("t3_no_pulse", pulses - p0, 0);

        // Two columns low on row 0: rows keep rotating, nothing accepted.
        p0       = pulses;
        key_mask = 16'h0003;
        prev     = row_out;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (row_out === prev && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t4_rotate", row_out, {prev[2:0], prev[3]});
            prev = row_out;
        end
        check("t4_no_pulse", pulses - p0, 0);
        key_mask = 16'h0000;
        repeat (4) @(negedge clk);

        // Hold 5, add 6 during release: only 5 is taken.
        p0       = pulses;
        key_mask = 16'd1 << 5;
        wait_valid(ok);
        @(negedge clk);
        exp_q.push_back(4'd5);
        repeat (10) @(negedge clk);
        check("t5_pressed", pressed, 1);
        key_mask = key_mask | (16'd1 << 6);
        repeat (60) @(negedge clk);
        check("t5_single_pulse", pulses - p0, 1);
        check("t5_still_pressed", pressed, 1);
        key_mask = 16'h0000;
        wait_released();
        check("t5_pulse_after_release", pulses - p0, 1);
        check("t5_key_code", key_code, 5);
        check("t5_hexs", hexs, model_hexs());
        press_key(6, 1'b0, 30);

        // clr in the ACCEPT cycle wins over the shift.
        press_key(7, 1'b1, 30);
        check("t6_clr_hexs", hexs, 0);
        check("t6_clr_count", key_count, 0);

        // rst in the middle of debouncing key 9.
        p0 = pulses;
        wait_row(4'b1011);
        key_mask = 16'd1 << 9;
        repeat (5) @(negedge clk);
        check("t6_debounce_row_held", row_out, 4'b1011);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_row_out", row_out, 4'b1110);
        check("t6_rst_pressed", pressed, 0);
        check("t6_rst_key_valid", key_valid, 0);
        check("t6_rst_key_code", key_code, 0);
        check("t6_rst_hexs", hexs, 0);
        check("t6_rst_key_count", key_count, 0);
        rst      = 1'b0;
        key_mask = 16'h0000;
        exp_q.delete();
        check("t6_no_pulse", pulses - p0, 0);
        repeat (4) @(negedge clk);

        // Random keys and hold times.
        for (int i = 0; i < 6; i++) begin
            press_key(int'($urandom_range(0, 15)), 1'b0, int'($urandom_range(25, 70)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_hex_entry.md
Name: keypad_hex_entry

Overview:
- Input-side counterpart to the board's 4-digit hex display path: scans a 4x4 matrix keypad, debounces presses and produces 4-bit hex key codes.
- Shifts each accepted key into a 16-bit value, `hexs`, which drives the display block's `hexs` input directly.
- Runs on the board clock.

Parameters:
- SCAN_DIV, 4096: clocks per scan tick (row slot / debounce sample period); legal minimum 4.
- DEBOUNCE_CNT, 4: consecutive identical tick samples required to accept a press or a release; legal minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of `hexs` and `key_count`; does not affect the scan FSM.
- col_in  input  4  keypad columns, active-low (pulled up); asynchronous to clk.
- row_out  output  4  keypad row drive, active-low, exactly one bit low at all times.
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a key is accepted.
- hexs  output  16  shifted entry value, newest key in [3:0].
- key_count  output  3  keys entered since reset/clr, saturates at 4.
- pressed  output  1  high while a key is accepted and not yet released.

Behaviour:
- Reset values: row_out=4'b1110, key_code=0, key_valid=0, hexs=0, key_count=0, pressed=0; FSM=SCAN; tick counter=0; debounce counter=0; sync flops=4'b1111.
- col_in passes through a 2-flop synchronizer; col_s denotes the synchronized value.
- Tick counter runs 0..SCAN_DIV-1 and wraps. `tick` is asserted in the cycle where the count equals SCAN_DIV-1. All sampling below happens only on tick cycles.
- Row index r (0..3) selects row_out = ~(1<<r).
- A pattern is valid when exactly one bit of col_s is 0; c = index of that bit.
- Key code = 4*r + c.
- FSM states:
  - SCAN:
    - On tick with col_s==4'b1111: r <= r+1 (wraps 3->0).
    - On tick with a valid pattern: latch the pattern, set debounce count=1, go to DEBOUNCE; r is held.
    - On tick with more than one column low: treated as all-high, so r advances.
  - DEBOUNCE:
    - On tick with col_s equal to the latched pattern: count+1.
    - When the count reaches DEBOUNCE_CNT, go to ACCEPT. With DEBOUNCE_CNT=1, go from SCAN straight to ACCEPT on the first tick.
    - On tick with col_s different from the latched pattern: go to SCAN, r <= r+1, no output.
  - ACCEPT (one cycle):
    - key_valid=1; key_code <= 4*r+c; hexs <= {hexs[11:0], code}; key_count <= min(key_count+1, 4); pressed <= 1.
    - Go to RELEASE with count=0.
  - RELEASE:
    - On tick with col_s==4'b1111: count+1; otherwise count <= 0.
    - When the count reaches DEBOUNCE_CNT: pressed <= 0, r <= r+1, go to SCAN.
- A second key pressed while in RELEASE is ignored and gives no auto-repeat.
- key_valid is high only in the ACCEPT cycle.
- clr coinciding with ACCEPT: clr wins, so hexs=0 and key_count=0; key_valid still pulses and key_code still updates.
- rst at any point, including mid-debounce or in RELEASE, returns every register to its reset value on the next edge.
- hexs shifts out the oldest nibble after 4 keys (a 16-bit window); key_count stays at 4.

Test Plan:
Bench settings: SCAN_DIV=4, DEBOUNCE_CNT=3, col_in default 4'b1111.
1. Press row2/col1: drive col_in=4'b1101 whenever row_out==4'b1011; hold >20 ticks, then release -> exactly one key_valid pulse, key_code=4'h9, hexs=16'h0009, pressed high until 3 all-high ticks after release, then row_out resumes rotating.
2. Enter keys 1,2,3,A,F in sequence (row/col chosen so 4r+c gives each code) -> hexs reads 0001, 0012, 0123, 123A, 23AF; key_count saturates at 4.
3. Bounce: pattern present for 2 ticks, then released, then restored -> no key_valid; FSM returns to SCAN and row_out advances.
4. Two columns low (col_in=4'b1100) on the active row -> no key_valid ever; row_out keeps rotating 1110→1101→1011→0111→1110.
5. Hold key 5, then additionally press key 6 during RELEASE -> only code 5 is accepted; no pulse until all keys are released and key 6 is re-pressed.
6. Assert clr in the same cycle as ACCEPT, then assert rst during DEBOUNCE -> after clr: hexs=0, key_count=0, key_valid pulsed; after rst: row_out=1110, pressed=0 and all outputs at reset values next cycle.
